// File: rtl/ps2_joy_if.sv
// PS/2 pin inputs and decoded pad/keyboard outputs of ps2_joy.
// The slave modport is the receiver's view; master is the board/PPU side.
interface ps2_joy_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       err;

  modport slave (
    input  ps2_clk, ps2_dat,
    output joy1, joy2, kbd_data, kbd_valid, err
  );

  modport master (
    output ps2_clk, ps2_dat,
    input  joy1, joy2, kbd_data, kbd_valid, err
  );
endinterface

// File: rtl/ps2_joy.sv
// Receive-only PS/2 keyboard front end that keeps two NES pad states from set-2 make/break codes.
// Define PS2_GLITCH_FILTER_EN to qualify ps2_clk with a FILTER-cycle stability filter before edge detection.
module ps2_joy #(
  parameter int TIMEOUT = 50000,
  parameter int FILTER  = 8
) (
  input  logic      clock,
  input  logic      reset,
  ps2_joy_if.slave  bus
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic           edge_lvl, edge_prev, fall;
  logic [9:0]     sh;
  logic [10:0]    frame;
  logic [3:0]     cnt;
  logic [WDW-1:0] wd;
  logic           rel, ext;
  logic [7:0]     joy1, joy2, kbd_data;
  logic           kbd_valid, err;
  logic [4:0]     key;
  logic           frame_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER + 1);
  logic          filt;
  logic [FW-1:0] fcnt;

  // The filtered level follows only after FILTER consecutive disagreeing cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s2 != filt) begin
      if (fcnt == FW'(FILTER - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else begin
      fcnt <= '0;
    end
  end

  assign edge_lvl = filt;
`else
  assign edge_lvl = clk_s2;
`endif

  always_ff @(posedge clock) begin
    if (reset) edge_prev <= 1'b1;
    else       edge_prev <= edge_lvl;
  end

  assign fall     = edge_prev & ~edge_lvl;
  assign frame    = {dat_s2, sh};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  // {hit, player2, bit index}
  function automatic logic [4:0] map_key(input logic [7:0] b);
    case (b)
      8'h22: map_key = 5'b10_000;
      8'h1A: map_key = 5'b10_001;
      8'h21: map_key = 5'b10_010;
      8'h5A: map_key = 5'b10_011;
      8'h75: map_key = 5'b10_100;
      8'h72: map_key = 5'b10_101;
      8'h6B: map_key = 5'b10_110;
      8'h74: map_key = 5'b10_111;
      8'h42: map_key = 5'b11_000;
      8'h3B: map_key = 5'b11_001;
      8'h3C: map_key = 5'b11_010;
      8'h43: map_key = 5'b11_011;
      8'h1D: map_key = 5'b11_100;
      8'h1B: map_key = 5'b11_101;
      8'h1C: map_key = 5'b11_110;
      8'h23: map_key = 5'b11_111;
      default: map_key = 5'b00_000;
    endcase
  endfunction

  assign key = map_key(frame[8:1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      sh        <= '0;
      cnt       <= '0;
      wd        <= '0;
      rel       <= 1'b0;
      ext       <= 1'b0;
      joy1      <= '0;
      joy2      <= '0;
      kbd_data  <= '0;
      kbd_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      kbd_valid <= 1'b0;
      err       <= 1'b0;
      if (fall) begin
        wd <= '0;
        if (cnt == 4'd10) begin
          cnt <= '0;
          if (frame_ok) begin
            kbd_valid <= 1'b1;
            kbd_data  <= frame[8:1];
            if (frame[8:1] == 8'hE0) begin
              ext <= 1'b1;
            end else if (frame[8:1] == 8'hF0) begin
              rel <= 1'b1;
            end else begin
              if (key[4]) begin
                if (key[3]) joy2[key[2:0]] <= ~rel;
                else        joy1[key[2:0]] <= ~rel;
              end
              rel <= 1'b0;
              ext <= 1'b0;
            end
          end else begin
            err <= 1'b1;
          end
        end else begin
          sh  <= frame[10:1];
          cnt <= cnt + 1'b1;
        end
      end else if (cnt != 4'd0) begin
        // A stalled frame is dropped silently once the line has been idle too long.
        if (wd == WDW'(TIMEOUT - 1)) begin
          cnt <= '0;
          wd  <= '0;
        end else begin
          wd <= wd + 1'b1;
        end
      end
    end
  end

  // ext is tracked but never steers the map: arrows alias keypad 8/2/4/6 and both Enters.
  logic unused_ext;
  assign unused_ext = ext;

  assign bus.joy1      = joy1;
  assign bus.joy2      = joy2;
  assign bus.kbd_data  = kbd_data;
  assign bus.kbd_valid = kbd_valid;
  assign bus.err       = err;
endmodule
